// File: rtl/hdmi_island_scheduler.sv
// Data-island scheduler for HDMI: grants one packet per island in fixed 56-clock slots placed in horizontal blanking.
// Optional build macro INFOFRAME_EN enables once-per-frame AVI and Audio InfoFrame requests.
module hdmi_island_scheduler #(
    parameter int FRAMEWIDTH  = 1280,
    parameter int TOTALWIDTH  = 1650,
    parameter int FRAMEHEIGHT = 720,
    parameter int TOTALHEIGHT = 750
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] hcnt,
    input  logic [10:0] vcnt,
    input  logic        acr_req,
    input  logic        aud_req,
    output logic [3:0]  gnt,
    output logic [1:0]  pkt_sel,
    output logic        isl_pre,
    output logic        isl_gbl,
    output logic        isl_data,
    output logic        isl_gbt,
    output logic [4:0]  bit_idx,
    output logic [7:0]  aud_late_cnt
);

    localparam int SLOT_PITCH = 56;
    localparam int SLOT0      = FRAMEWIDTH + 4;
    localparam int SLOT_LAST  = TOTALWIDTH - 12 - 44;
    localparam int NSLOT      = (SLOT_LAST < SLOT0) ? 0 : (SLOT_LAST - SLOT0) / SLOT_PITCH + 1;
    localparam int NSLOT_V    = (NSLOT > 0) ? NSLOT : 1;
    localparam logic [11:0] LAST_H = 12'(TOTALWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        GBL,
        DATA,
        GBT,
        GAP
    } state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [3:0]  gnt_reg;
    logic [1:0]  pkt_sel_reg;
    logic        isl_pre_reg;
    logic        isl_gbl_reg;
    logic        isl_data_reg;
    logic        isl_gbt_reg;
    logic [4:0]  bit_idx_reg;
    logic [7:0]  aud_late_cnt_reg;
    logic        avi_pend_reg;
    logic        aif_pend_reg;

    logic [NSLOT_V-1:0] slot_hit;
    logic        slot_start;
    logic [3:0]  gnt_next;
    logic [1:0]  sel_next;
    logic        can_start;

    // One comparator per slot position; positions are elaboration-time constants.
    generate
        for (genvar gi = 0; gi < NSLOT_V; gi++) begin : g_slot
            if (gi < NSLOT) begin : g_on
                assign slot_hit[gi] = (hcnt == 12'(SLOT0 + SLOT_PITCH * gi));
            end else begin : g_off
                assign slot_hit[gi] = 1'b0;
            end
        end
    endgenerate

    assign slot_start = |slot_hit;

    always_comb begin
        gnt_next = 4'b0000;
        sel_next = 2'd0;
        if (acr_req) begin
            gnt_next = 4'b0001;
            sel_next = 2'd0;
        end else if (aud_req) begin
            gnt_next = 4'b0010;
            sel_next = 2'd1;
        end else if (avi_pend_reg) begin
            gnt_next = 4'b0100;
            sel_next = 2'd2;
        end else if (aif_pend_reg) begin
            gnt_next = 4'b1000;
            sel_next = 2'd3;
        end
    end

    // The last GAP cycle coincides with the next slot start, so it accepts a new island like IDLE.
    assign can_start = slot_start && (gnt_next != 4'b0000) &&
                       ((state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == 5'd11)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 5'd0;
            gnt_reg      <= 4'b0000;
            pkt_sel_reg  <= 2'd0;
            isl_pre_reg  <= 1'b0;
            isl_gbl_reg  <= 1'b0;
            isl_data_reg <= 1'b0;
            isl_gbt_reg  <= 1'b0;
            bit_idx_reg  <= 5'd0;
        end else begin
            gnt_reg <= 4'b0000;
            if (can_start) begin
                state_reg   <= PRE;
                cnt_reg     <= 5'd0;
                gnt_reg     <= gnt_next;
                pkt_sel_reg <= sel_next;
                isl_pre_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        cnt_reg <= 5'd0;
                    end
                    PRE: begin
                        if (cnt_reg == 5'd7) begin
                            state_reg   <= GBL;
                            cnt_reg     <= 5'd0;
                            isl_pre_reg <= 1'b0;
                            isl_gbl_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                    GBL: begin
                        if (cnt_reg == 5'd1) begin
                            state_reg    <= DATA;
                            cnt_reg      <= 5'd0;
                            isl_gbl_reg  <= 1'b0;
                            isl_data_reg <= 1'b1;
                            bit_idx_reg  <= 5'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                    DATA: begin
                        if (cnt_reg == 5'd31) begin
                            state_reg    <= GBT;
                            cnt_reg      <= 5'd0;
                            isl_data_reg <= 1'b0;
                            isl_gbt_reg  <= 1'b1;
                            bit_idx_reg  <= 5'd0;
                        end else begin
                            cnt_reg     <= cnt_reg + 5'd1;
                            bit_idx_reg <= bit_idx_reg + 5'd1;
                        end
                    end
                    GBT: begin
                        if (cnt_reg == 5'd1) begin
                            state_reg   <= GAP;
                            cnt_reg     <= 5'd0;
                            isl_gbt_reg <= 1'b0;
                            pkt_sel_reg <= 2'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                    GAP: begin
                        if (cnt_reg == 5'd11) begin
                            state_reg <= IDLE;
                            cnt_reg   <= 5'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        cnt_reg      <= 5'd0;
                        pkt_sel_reg  <= 2'd0;
                        isl_pre_reg  <= 1'b0;
                        isl_gbl_reg  <= 1'b0;
                        isl_data_reg <= 1'b0;
                        isl_gbt_reg  <= 1'b0;
                        bit_idx_reg  <= 5'd0;
                    end
                endcase
            end
        end
    end

    // A line counts as late when it closes with audio still waiting and not granted right then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aud_late_cnt_reg <= 8'd0;
        end else if ((hcnt == LAST_H) && aud_req && !gnt_reg[1] &&
                     (aud_late_cnt_reg != 8'hFF)) begin
            aud_late_cnt_reg <= aud_late_cnt_reg + 8'd1;
        end
    end

`ifdef INFOFRAME_EN
    logic frame_start;
    assign frame_start = (hcnt == 12'd0) && (vcnt == 11'(FRAMEHEIGHT));

    // A new frame request takes precedence over a grant landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avi_pend_reg <= 1'b0;
            aif_pend_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                avi_pend_reg <= 1'b1;
            end else if (gnt_reg[2]) begin
                avi_pend_reg <= 1'b0;
            end
            if (frame_start) begin
                aif_pend_reg <= 1'b1;
            end else if (gnt_reg[3]) begin
                aif_pend_reg <= 1'b0;
            end
        end
    end
`else
    assign avi_pend_reg = 1'b0;
    assign aif_pend_reg = 1'b0;
`endif

    // Vertical geometry only matters for the InfoFrame trigger.
    logic unused_vgeom;
    assign unused_vgeom = ^{vcnt, 11'(TOTALHEIGHT), 11'(FRAMEHEIGHT)};

    assign gnt          = gnt_reg;
    assign pkt_sel      = pkt_sel_reg;
    assign isl_pre      = isl_pre_reg;
    assign isl_gbl      = isl_gbl_reg;
    assign isl_data     = isl_data_reg;
    assign isl_gbt      = isl_gbt_reg;
    assign bit_idx      = bit_idx_reg;
    assign aud_late_cnt = aud_late_cnt_reg;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: drives hcnt/vcnt itself and checks grants, phases and the late counter.
module tb_hdmi_island_scheduler;

    localparam int TW = 1650;
    localparam int TH = 750;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic        acr_req;
    logic        aud_req;
    logic [3:0]  gnt;
    logic [1:0]  pkt_sel;
    logic        isl_pre;
    logic        isl_gbl;
    logic        isl_data;
    logic        isl_gbt;
    logic [4:0]  bit_idx;
    logic [7:0]  aud_late_cnt;

    int errors = 0;
    int checks = 0;
    int act_cnt = 0;
    int gnt_cnt = 0;
    int aud_gnt_cnt = 0;
    bit hold_h = 1'b0;
    bit aud_auto = 1'b0;

    hdmi_island_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .acr_req      (acr_req),
        .aud_req      (aud_req),
        .gnt          (gnt),
        .pkt_sel      (pkt_sel),
        .isl_pre      (isl_pre),
        .isl_gbl      (isl_gbl),
        .isl_data     (isl_data),
        .isl_gbt      (isl_gbt),
        .bit_idx      (bit_idx),
        .aud_late_cnt (aud_late_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // After this returns, hcnt/vcnt hold the current cycle's position and the outputs belong to it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_h) begin
            if (hcnt == 12'(TW - 1)) begin
                hcnt = 12'd0;
                vcnt = (vcnt == 11'(TH - 1)) ? 11'd0 : vcnt + 11'd1;
            end else begin
                hcnt = hcnt + 12'd1;
            end
        end
        if (aud_auto) aud_req = ~gnt[1];
        if (gnt != 4'b0000 || isl_pre || isl_gbl || isl_data || isl_gbt) act_cnt++;
        if (gnt != 4'b0000) gnt_cnt++;
        if (gnt[1]) aud_gnt_cnt++;
    endtask

    task automatic run_to(input logic [11:0] h);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (hcnt != h && n < 4000);
        if (hcnt != h) chk("run_to_timeout", 32'(hcnt), 32'(h));
    endtask

    initial begin
        rst_n   = 1'b0;
        hcnt    = 12'd0;
        vcnt    = 11'd0;
        acr_req = 1'b0;
        aud_req = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_phases", 32'({isl_pre, isl_gbl, isl_data, isl_gbt}), 32'h0);
        chk("rst_bit_idx", 32'(bit_idx), 32'h0);
        chk("rst_pkt_sel", 32'(pkt_sel), 32'h0);
        chk("rst_late", 32'(aud_late_cnt), 32'h0);
        $display("step reset: hcnt=%0d gnt=%b late=%0d", hcnt, gnt, aud_late_cnt);
        rst_n = 1'b1;

        // Line with no requests: no islands at all
        act_cnt = 0;
        run_to(12'd0);
        chk("idle_line_activity", 32'(act_cnt), 32'd0);
        $display("step idle line: activity=%0d", act_cnt);

        // Audio request from hcnt 1200: island at slot 1284
        run_to(12'd1200);
        aud_req = 1'b1;
        run_to(12'd1284);
        chk("aud_pre_slot_gnt", 32'(gnt), 32'h0);
        tick();
        chk("aud_gnt_1285", 32'(gnt), 32'b0010);
        chk("aud_pkt_sel_1285", 32'(pkt_sel), 32'd1);
        chk("aud_pre_1285", 32'(isl_pre), 32'd1);
        $display("step audio grant: hcnt=%0d gnt=%b pkt_sel=%0d", hcnt, gnt, pkt_sel);
        aud_req = 1'b0;
        run_to(12'd1292);
        chk("aud_pre_1292", 32'({isl_pre, gnt}), 32'b10000);
        run_to(12'd1293);
        chk("aud_gbl_1293", 32'({isl_pre, isl_gbl}), 32'b01);
        run_to(12'd1295);
        chk("aud_data_1295", 32'({isl_gbl, isl_data, bit_idx}), 32'b01_00000);
        run_to(12'd1326);
        chk("aud_data_1326", 32'({isl_data, bit_idx, pkt_sel}), 32'b1_11111_01);
        run_to(12'd1327);
        chk("aud_gbt_1327", 32'({isl_data, isl_gbt, bit_idx}), 32'b01_00000);
        run_to(12'd1329);
        chk("aud_end_1329", 32'({isl_gbt, pkt_sel}), 32'h0);
        run_to(12'd1341);
        chk("aud_withdrawn_1341", 32'({gnt, isl_pre}), 32'h0);
        run_to(12'd0);
        chk("aud_late_none", 32'(aud_late_cnt), 32'd0);
        $display("step audio island: late=%0d", aud_late_cnt);

        // ACR and audio together: ACR first, audio next slot
        run_to(12'd1000);
        acr_req = 1'b1;
        aud_req = 1'b1;
        run_to(12'd1285);
        chk("prio_acr_gnt", 32'({gnt, pkt_sel}), 32'b0001_00);
        acr_req = 1'b0;
        run_to(12'd1340);
        chk("prio_gap_1340", 32'({gnt, isl_pre, isl_gbt}), 32'h0);
        tick();
        chk("prio_aud_gnt", 32'({gnt, pkt_sel}), 32'b0010_01);
        $display("step priority: hcnt=%0d gnt=%b pkt_sel=%0d", hcnt, gnt, pkt_sel);
        aud_req = 1'b0;
        run_to(12'd0);

        // Audio pulse between slots, withdrawn before 1340
        run_to(12'd1286);
        aud_req = 1'b1;
        run_to(12'd1301);
        aud_req = 1'b0;
        act_cnt = 0;
        run_to(12'd0);
        chk("pulse_no_island", 32'(act_cnt), 32'd0);
        chk("pulse_late", 32'(aud_late_cnt), 32'd0);
        $display("step pulse: activity=%0d late=%0d", act_cnt, aud_late_cnt);

        // Audio re-requested after every grant: 6 grants and one late line each line
        aud_auto = 1'b1;
        aud_req = 1'b1;
        aud_gnt_cnt = 0;
        run_to(12'd0);
        chk("auto_grants_l1", 32'(aud_gnt_cnt), 32'd6);
        chk("auto_late_l1", 32'(aud_late_cnt), 32'd1);
        aud_gnt_cnt = 0;
        run_to(12'd0);
        chk("auto_grants_l2", 32'(aud_gnt_cnt), 32'd6);
        chk("auto_late_l2", 32'(aud_late_cnt), 32'd2);
        $display("step auto audio: grants=%0d late=%0d", aud_gnt_cnt, aud_late_cnt);

        // Hold the line end to drive the counter into saturation
        run_to(12'(TW - 1));
        hold_h = 1'b1;
        repeat (252) tick();
        chk("late_254", 32'(aud_late_cnt), 32'd254);
        tick();
        chk("late_255", 32'(aud_late_cnt), 32'd255);
        repeat (5) tick();
        chk("late_sat", 32'(aud_late_cnt), 32'd255);
        $display("step saturation: late=%0d", aud_late_cnt);

        // Frame start line: InfoFrames only when enabled
        hold_h = 1'b0;
        aud_auto = 1'b0;
        aud_req = 1'b0;
        vcnt = 11'd719;
        run_to(12'd0);
        gnt_cnt = 0;
        run_to(12'd1285);
`ifdef INFOFRAME_EN
        chk("if_avi_gnt", 32'({gnt, pkt_sel}), 32'b0100_10);
`else
        chk("if_off_gnt_1285", 32'(gnt), 32'h0);
`endif
        run_to(12'd1341);
`ifdef INFOFRAME_EN
        chk("if_aif_gnt", 32'({gnt, pkt_sel}), 32'b1000_11);
`else
        chk("if_off_gnt_1341", 32'(gnt), 32'h0);
`endif
        run_to(12'd0);
`ifdef INFOFRAME_EN
        chk("if_grants_line", 32'(gnt_cnt), 32'd2);
`else
        chk("if_off_grants_line", 32'(gnt_cnt), 32'd0);
`endif
        $display("step infoframe line: grants=%0d", gnt_cnt);

        // Reset at t+20 of an audio island, audio still held
        run_to(12'd1200);
        aud_req = 1'b1;
        run_to(12'd1285);
        chk("rst_isl_gnt", 32'(gnt), 32'b0010);
        run_to(12'd1304);
        rst_n = 1'b0;
        tick();
        chk("rst_isl_outputs", 32'({gnt, pkt_sel, isl_pre, isl_gbl, isl_data, isl_gbt, bit_idx}), 32'h0);
        chk("rst_isl_late", 32'(aud_late_cnt), 32'd0);
        rst_n = 1'b1;
        act_cnt = 0;
        run_to(12'd1340);
        chk("rst_quiet", 32'(act_cnt), 32'd0);
        tick();
        chk("rst_next_gnt", 32'({gnt, isl_pre}), 32'b0010_1);
        $display("step reset mid-island: hcnt=%0d gnt=%b", hcnt, gnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
